dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the word-indexed data memory. It shares the memory between the core load/store path (port 0) and a debug/DMA loader (port 1). Each access is latched, then driven onto the memory's address/data/read/write/func3 interface for exactly one cycle. Each access returns a registered response with a legality check. It sits between the requesters and the data memory; nothing else drives the memory.

## Interface
- DEPTH, 40, number of 32-bit words in the data memory; legal addresses are 0..DEPTH-1
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_i[p], p=0,1  in  1  access request; held with its fields stable until gnt_o[p]
- we_i[p]  in  1  1=store, 0=load
- addr_i[p]  in  32  word index
- wdata_i[p]  in  32  store data
- func3_i[p]  in  3  load/store size code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- gnt_o[p]  out  1  one-cycle accept pulse
- rvalid_o[p]  out  1  one-cycle response pulse, for loads and stores
- rdata_o[p]  out  32  load data, valid with rvalid_o[p]; 0 for stores and errors
- err_o[p]  out  1  illegal access, valid with rvalid_o[p]
- mem_addr_o  out  32  to memory addr
- mem_wdata_o  out  32  to memory write_data
- mem_read_o  out  1  to memory mem_read
- mem_write_o  out  1  to memory mem_write
- mem_func3_o  out  3  to memory func3
- mem_rdata_i  in  32  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: if any req_i, pick winner, assert gnt_o[winner] combinationally this cycle, latch winner's we/addr/wdata/func3/port id, go ACCESS; else stay.
- ACCESS: drive latched fields to memory.
  - Load: mem_read_o=1. Store: mem_write_o=1.
  - Capture mem_rdata_i (loads) into response register. Go IDLE.
- Response: rvalid_o[port] pulses in the cycle after ACCESS, which is also an IDLE cycle. A new grant may occur in that same cycle.
- Legality is checked on latched fields in ACCESS:
  - addr >= DEPTH is illegal.
  - Load with func3 in {011,110,111} is illegal.
  - Store with func3 not in {000,001,010} is illegal.
  - Illegal: mem_read_o=mem_write_o=0, err_o=1, rdata_o=0; memory unchanged.
- Outside ACCESS: mem_read_o=mem_write_o=0; mem_addr/wdata/func3 hold latched values.
- Both req_i high in IDLE: winner per arbitration policy (see Configuration); loser keeps req_i high and is served next IDLE.
- A requester must not drop req_i before gnt_o; behaviour if it does is unspecified, except that no grant is issued to a port whose req_i is low.

## Timing
- Reset values: state=IDLE; gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, mem_func3_o=0; RR pointer=port 1.
- Latency: gnt in cycle N, memory access in N+1, rvalid in N+2.
- Throughput: one access per 2 cycles, back-to-back grants at N, N+2, N+4.
- Store takes effect at the rising edge ending cycle N+1; a load granted at N+2 sees it.
- Reset asserted in ACCESS: access aborted, no memory write (mem_write_o forced 0 that cycle), no rvalid issued afterwards.
- Reset asserted while rvalid due: pulse suppressed.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - Pointer records the last granted port; on a tie, the other port wins.
  - Reset pointer = 1, so port 0 wins the first tie.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; no pointer register.

## Structure
- Package dmem_pkg:
  - func3 enum: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - arb_state_t enum {IDLE, ACCESS}.
  - Request struct {we, addr, wdata, func3}.
- One sub-module: dmem_arb_pick, the 2-way winner select.
  - Inputs: req vector and pointer.
  - Output: one-hot grant.
  - Policy selected by DMEM_ARB_RR_EN.

## Test plan
- Port 0 SW addr 5 data 0xDEADBEEF, then LW addr 5 -> gnt at N and N+2; second rvalid_o[0] at N+4 with rdata 0xDEADBEEF, err 0.
- Store 0x000000F0 to addr 3, then port 1 LB addr 3 -> rdata 0xFFFFFFF0; LBU addr 3 -> 0x000000F0.
- Both ports request every cycle for 8 grants:
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: port 0 takes all grants while it requests.
- Load addr 40 (DEPTH=40), and store with func3=011 -> rvalid with err 1, rdata 0, mem_read_o/mem_write_o never high, memory contents unchanged.
- rst_n low during ACCESS of a store to addr 7 (prior value 0x11111111) -> addr 7 still 0x11111111; no rvalid; state IDLE after release.
- Single request with no contention -> gnt same cycle req first seen in IDLE; mem_read_o high exactly one cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory arbiter.
// Provides the load/store size codes, the arbiter state type, the latched
// request record and the access legality rule used in the ACCESS cycle.
package dmem_pkg;

    localparam int unsigned NPORTS = 2;
    localparam int unsigned XLEN   = 32;

    // Load size codes
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    // Store size codes (share encodings with the loads)
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      func3;
    } dmem_req_t;

    // An access is legal when the word index is in range and the size code
    // is one the memory understands for that direction.
    function automatic logic access_legal(input dmem_req_t r, input logic [XLEN-1:0] depth);
        logic ok;
        ok = (r.addr < depth);
        if (r.we) begin
            ok = ok && (r.func3 inside {SB, SH, SW});
        end else begin
            ok = ok && (r.func3 inside {LB, LH, LW, LBU, LHU});
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way winner select, one-hot grant out.
// Build option DMEM_ARB_RR_EN: when defined, ties go to the port that was
// not granted last (ptr = last granted port); when undefined, port 0 always
// wins ties and ptr is ignored.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              ptr,
    output logic [NPORTS-1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
    // Round-robin select: a lone requester wins, a tie goes away from ptr
    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    // Fixed priority select: port 0 first
    always_comb begin
        gnt = '0;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the word-indexed data memory between the core
// load/store path (port 0) and the debug/DMA loader (port 1).
// An access is granted in IDLE, driven onto the memory for one ACCESS cycle,
// and answered with a registered rvalid/rdata/err pulse the cycle after.
// Build option DMEM_ARB_RR_EN selects round-robin tie-breaking; without it
// port 0 has fixed priority and no pointer register exists.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; grants combinationally and latches it
// ACCESS | latched request on the memory bus, legality gating read/write
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORTS-1:0]            req_i,
    input  logic [NPORTS-1:0]            we_i,
    input  logic [NPORTS-1:0][XLEN-1:0]  addr_i,
    input  logic [NPORTS-1:0][XLEN-1:0]  wdata_i,
    input  logic [NPORTS-1:0][2:0]       func3_i,
    output logic [NPORTS-1:0]            gnt_o,
    output logic [NPORTS-1:0]            rvalid_o,
    output logic [NPORTS-1:0][XLEN-1:0]  rdata_o,
    output logic [NPORTS-1:0]            err_o,
    output logic [XLEN-1:0]              mem_addr_o,
    output logic [XLEN-1:0]              mem_wdata_o,
    output logic                         mem_read_o,
    output logic                         mem_write_o,
    output logic [2:0]                   mem_func3_o,
    input  logic [XLEN-1:0]              mem_rdata_i
);

    localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DEPTH);

    arb_state_t        state_q;
    arb_state_t        state_d;
    dmem_req_t         lat_q;
    dmem_req_t         win_req;
    logic              lat_port_q;
    logic [NPORTS-1:0] pick;
    logic              win_port;
    logic              arb_ptr;
    logic              take;
    logic              legal;
    logic              rd_en;
    logic              wr_en;

    logic              rsp_valid_q;
    logic              rsp_port_q;
    logic              rsp_err_q;
    logic [XLEN-1:0]   rsp_rdata_q;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q;

    // Remember the last granted port; reset favours port 0 on the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (take) begin
            ptr_q <= win_port;
        end
    end

    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = 1'b1;
`endif

    dmem_arb_pick u_pick (
        .req (req_i),
        .ptr (arb_ptr),
        .gnt (pick)
    );

    assign win_port = pick[1];
    assign legal    = access_legal(lat_q, DEPTH_W);

    // Gather the winning port's fields into one record
    always_comb begin
        win_req       = '0;
        win_req.we    = we_i[win_port];
        win_req.addr  = addr_i[win_port];
        win_req.wdata = wdata_i[win_port];
        win_req.func3 = func3_i[win_port];
    end

    // Next state and memory strobes
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rd_en   = legal && !lat_q.we;
                wr_en   = legal && lat_q.we;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the granted request; it stays on the memory bus until the next grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_q      <= '0;
            lat_port_q <= 1'b0;
        end else if (take) begin
            lat_q      <= win_req;
            lat_port_q <= win_port;
        end
    end

    // Response register, loaded at the end of ACCESS
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= (state_q == ACCESS);
            if (state_q == ACCESS) begin
                rsp_port_q  <= lat_port_q;
                rsp_err_q   <= !legal;
                rsp_rdata_q <= rd_en ? mem_rdata_i : '0;
            end
        end
    end

    // Reset is synchronous, so strobes are also masked combinationally: a
    // store caught by reset in ACCESS must not reach the memory, and a due
    // response must not pulse while reset is low.
    assign gnt_o       = (take && rst_n) ? pick : '0;
    assign mem_read_o  = rd_en && rst_n;
    assign mem_write_o = wr_en && rst_n;
    assign mem_addr_o  = lat_q.addr;
    assign mem_wdata_o = lat_q.wdata;
    assign mem_func3_o = lat_q.func3;

    // Steer the response to the port that issued it
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (rsp_valid_q && rst_n) begin
            rvalid_o[rsp_port_q] = 1'b1;
            err_o[rsp_port_q]    = rsp_err_q;
            rdata_o[rsp_port_q]  = rsp_rdata_q;
        end
    end

endmodule
